// File: rtl/m3ds_sram_arb_pkg.sv
// Shared definitions for the two-master SRAM bank port arbiter:
// owner-state encoding, master indices and the default starvation limit.
package m3ds_sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } owner_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int STARVE_MAX_DEF = 8;

endpackage

// File: rtl/m3ds_sram_arb_starve_cnt.sv
// M1 starvation timer: loads STARVE_MAX, counts down on every cycle M1 waits,
// and flags starvation at terminal count. Built only with SRAM_ARB_FAIRNESS_EN.
`ifdef SRAM_ARB_FAIRNESS_EN
module m3ds_sram_arb_starve_cnt #(
    parameter int STARVE_MAX = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic wait_req,
    input  logic gnt,
    output logic starved
);
    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || gnt)
            cnt <= CW'(STARVE_MAX);
        else if (wait_req && cnt != '0)
            cnt <= cnt - CW'(1);
    end

    assign starved = (cnt == '0);

endmodule
`endif

// File: rtl/m3ds_sram_port_arbiter.sv
// Two-master (CPU bridge / DMA) arbiter for one SRAM bank port with lock support.
// Define SRAM_ARB_FAIRNESS_EN to add a forced M1 grant after STARVE_MAX waiting cycles.
//
// state | meaning
// IDLE  | no owner, fixed priority M0 > M1
// OWN0  | M0 holds the port while M0LOCK & M0REQ
// OWN1  | M1 holds the port while M1LOCK & M1REQ
module m3ds_sram_port_arbiter
    import m3ds_sram_arb_pkg::*;
#(
    parameter int AW         = 13,
    parameter int DW         = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              SRAMHCLK,
    input  logic              SRAMHRESET,
    input  logic              M0REQ,
    input  logic              M0LOCK,
    input  logic [AW-1:0]     M0ADDR,
    input  logic [DW/8-1:0]   M0WREN,
    input  logic [DW-1:0]     M0WDATA,
    output logic              M0GNT,
    output logic              M0RVALID,
    output logic [DW-1:0]     M0RDATA,
    input  logic              M1REQ,
    input  logic              M1LOCK,
    input  logic [AW-1:0]     M1ADDR,
    input  logic [DW/8-1:0]   M1WREN,
    input  logic [DW-1:0]     M1WDATA,
    output logic              M1GNT,
    output logic              M1RVALID,
    output logic [DW-1:0]     M1RDATA,
    output logic [AW-1:0]     SRAMADDR,
    output logic [DW/8-1:0]   SRAMWREN,
    output logic [DW-1:0]     SRAMWDATA,
    output logic              SRAMCS,
    input  logic [DW-1:0]     SRAMRDATA
);
    localparam int BW = DW / 8;

    owner_e          state_q, state_d;
    logic            gnt0, gnt1, lock1, force1;
    logic [AW-1:0]   addr_q;
    logic [BW-1:0]   wren_q, wren_mux;
    logic [DW-1:0]   wdata_q;
    logic            rvalid_q, rd_owner_q;

`ifdef SRAM_ARB_FAIRNESS_EN
    logic starved;

    m3ds_sram_arb_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_starve_cnt (
        .clk      (SRAMHCLK),
        .rst      (SRAMHRESET),
        .wait_req (M1REQ & ~gnt1),
        .gnt      (gnt1),
        .starved  (starved)
    );

    // A starved M1 also breaks an M0 lock.
    assign force1 = starved & M1REQ;
`else
    logic unused_starve_max;
    assign unused_starve_max = (STARVE_MAX > 0);
    assign force1 = 1'b0;
`endif

    assign lock1 = (state_q == OWN1) & M1LOCK & M1REQ;

    always_comb begin
        state_d = IDLE;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        if (!SRAMHRESET) begin
            if (lock1 || force1)
                gnt1 = 1'b1;
            else if (M0REQ)
                gnt0 = 1'b1;
            else if (M1REQ)
                gnt1 = 1'b1;

            if (gnt0 && M0LOCK)
                state_d = OWN0;
            else if (gnt1 && M1LOCK)
                state_d = OWN1;
        end
    end

    always_ff @(posedge SRAMHCLK) begin
        if (SRAMHRESET)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    assign M0GNT  = gnt0;
    assign M1GNT  = gnt1;
    assign SRAMCS = gnt0 | gnt1;

    // Without a grant the port keeps presenting the last granted access.
    assign SRAMADDR  = gnt1 ? M1ADDR  : (gnt0 ? M0ADDR  : addr_q);
    assign SRAMWDATA = gnt1 ? M1WDATA : (gnt0 ? M0WDATA : wdata_q);
    assign wren_mux  = gnt1 ? M1WREN  : (gnt0 ? M0WREN  : wren_q);
    assign SRAMWREN  = SRAMHRESET ? '0 : wren_mux;

    always_ff @(posedge SRAMHCLK) begin
        if (SRAMHRESET) begin
            addr_q     <= '0;
            wren_q     <= '0;
            wdata_q    <= '0;
            rvalid_q   <= 1'b0;
            rd_owner_q <= M0;
        end else begin
            if (SRAMCS) begin
                addr_q  <= SRAMADDR;
                wren_q  <= wren_mux;
                wdata_q <= SRAMWDATA;
            end
            rvalid_q <= SRAMCS && (wren_mux == '0);
            if (SRAMCS)
                rd_owner_q <= gnt1 ? M1 : M0;
        end
    end

    assign M0RVALID = rvalid_q & ~SRAMHRESET & (rd_owner_q == M0);
    assign M1RVALID = rvalid_q & ~SRAMHRESET & (rd_owner_q == M1);
    assign M0RDATA  = SRAMRDATA;
    assign M1RDATA  = SRAMRDATA;

endmodule
